// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end for the 110 sequence detector. It has a
// one-word hold buffer so that consecutive words stream out with no idle bit between them.
module seq_bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             serial_en,
    output logic             out_bit,
    output logic             out_valid,
    output logic             word_start,
    output logic             busy
);

    localparam int             CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] hold_data;
    logic             hold_full;
    logic [WIDTH-1:0] sh;
    logic [CW-1:0]    count;
    logic             load_now;
    logic             accept;

    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] drop(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    // load_now must not depend on din_valid. This keeps din_ready free of any
    // combinational path back from the upstream handshake.
    assign load_now  = hold_full && serial_en && (!out_valid || count == LAST);
    assign din_ready = rst && (!hold_full || load_now);
    assign accept    = din_valid && din_ready;
    assign busy      = out_valid || hold_full;

    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_data  <= '0;
            hold_full  <= 1'b0;
            sh         <= '0;
            count      <= '0;
            out_bit    <= 1'b0;
            out_valid  <= 1'b0;
            word_start <= 1'b0;
        end else begin
            if (load_now) begin
                sh         <= drop(hold_data);
                out_bit    <= head(hold_data);
                count      <= '0;
                out_valid  <= 1'b1;
                word_start <= 1'b1;
            end else if (serial_en && out_valid) begin
                if (count == LAST) begin
                    // Drive idle zeros so the detector never sees a false 110.
                    out_valid  <= 1'b0;
                    out_bit    <= 1'b0;
                    word_start <= 1'b0;
                    count      <= '0;
                end else begin
                    out_bit    <= head(sh);
                    sh         <= drop(sh);
                    count      <= count + 1'b1;
                    word_start <= 1'b0;
                end
            end

            if (accept) begin
                hold_data <= din;
                hold_full <= 1'b1;
            end else if (load_now) begin
                hold_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer: one MSB-first instance and one LSB-first instance.
module tb_seq_bit_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din, din_l;
    logic       din_valid, din_valid_l;
    logic       din_ready, din_ready_l;
    logic       serial_en, serial_en_l;
    logic       out_bit, out_valid, word_start, busy;
    logic       out_bit_l, out_valid_l, word_start_l, busy_l;

    int checks   = 0;
    int failures = 0;

    logic [23:0] seq = {8'hD8, 8'h6C, 8'hA5};
    logic [7:0]  wa5 = 8'hA5;
    logic [7:0]  lsb_exp = 8'b1101_1000;

    always #5 clk = ~clk;

    seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .serial_en(serial_en), .out_bit(out_bit), .out_valid(out_valid),
        .word_start(word_start), .busy(busy)
    );

    seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .din(din_l), .din_valid(din_valid_l), .din_ready(din_ready_l),
        .serial_en(serial_en_l), .out_bit(out_bit_l), .out_valid(out_valid_l),
        .word_start(word_start_l), .busy(busy_l)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; din = '0; din_valid = 1'b0; serial_en = 1'b1;
        din_l = '0; din_valid_l = 1'b0; serial_en_l = 1'b1;

        // reset
        tick(); tick();
        chk("rst_out_bit", out_bit, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_word_start", word_start, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_din_ready", din_ready, 1'b0);
        rst = 1'b1;
        #1;
        chk("rel_din_ready", din_ready, 1'b1);
        tick();

        // single word D8
        din = 8'hD8; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        chk("single_busy_held", busy, 1'b1);
        chk("single_not_yet_valid", out_valid, 1'b0);
        tick();
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("single_bit%0d", k), out_bit, seq[23-k]);
            chk($sformatf("single_valid%0d", k), out_valid, 1'b1);
            chk($sformatf("single_ws%0d", k), word_start, k == 0);
            tick();
        end
        chk("single_idle_valid", out_valid, 1'b0);
        chk("single_idle_bit", out_bit, 1'b0);
        chk("single_idle_busy", busy, 1'b0);
        tick();

        // back-to-back D8, 6C
        din = 8'hD8; din_valid = 1'b1;
        tick();
        din = 8'h6C;
        tick();
        din_valid = 1'b0;
        chk("b2b_ready_low_full", din_ready, 1'b0);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("b2b_bit%0d", k), out_bit, seq[23-k]);
            chk($sformatf("b2b_valid%0d", k), out_valid, 1'b1);
            chk($sformatf("b2b_ws%0d", k), word_start, (k == 0) || (k == 8));
            if (k == 3) chk("b2b_ready_mid", din_ready, 1'b0);
            if (k == 7) chk("b2b_ready_last", din_ready, 1'b1);
            tick();
        end
        chk("b2b_idle_valid", out_valid, 1'b0);
        chk("b2b_idle_bit", out_bit, 1'b0);
        tick();

        // freeze mid-word with a third word waiting
        din = 8'hD8; din_valid = 1'b1;
        tick();
        din = 8'h6C;
        tick();
        din_valid = 1'b0;
        tick(); tick(); tick();
        serial_en = 1'b0; din = 8'hA5; din_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("frz_ready%0d", i), din_ready, 1'b0);
            chk($sformatf("frz_bit%0d", i), out_bit, 1'b1);
            chk($sformatf("frz_valid%0d", i), out_valid, 1'b1);
            chk($sformatf("frz_ws%0d", i), word_start, 1'b0);
            tick();
        end
        chk("frz_bit_after", out_bit, 1'b1);
        serial_en = 1'b1;
        for (int k = 3; k < 24; k++) begin
            if (k == 8) din_valid = 1'b0;
            chk($sformatf("frz_seq_bit%0d", k), out_bit, seq[23-k]);
            chk($sformatf("frz_seq_valid%0d", k), out_valid, 1'b1);
            chk($sformatf("frz_seq_ws%0d", k), word_start, (k == 8) || (k == 16));
            if (k == 7) chk("frz_ready_take", din_ready, 1'b1);
            tick();
        end
        chk("frz_idle_valid", out_valid, 1'b0);
        chk("frz_idle_busy", busy, 1'b0);
        tick();

        // reset at bit 4 with a word held
        din = 8'hD8; din_valid = 1'b1;
        tick();
        din = 8'h6C;
        tick();
        din_valid = 1'b0;
        tick(); tick(); tick(); tick();
        chk("mrst_pre_bit4", out_bit, seq[23-4]);
        chk("mrst_pre_busy", busy, 1'b1);
        rst = 1'b0;
        #1;
        chk("mrst_ready_in_rst", din_ready, 1'b0);
        tick();
        chk("mrst_valid", out_valid, 1'b0);
        chk("mrst_bit", out_bit, 1'b0);
        chk("mrst_ws", word_start, 1'b0);
        chk("mrst_busy", busy, 1'b0);
        rst = 1'b1;
        tick(); tick();
        chk("mrst_held_lost", out_valid, 1'b0);
        chk("mrst_busy_after", busy, 1'b0);
        din = 8'hA5; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        tick();
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("mrst_a5_bit%0d", k), out_bit, wa5[7-k]);
            chk($sformatf("mrst_a5_ws%0d", k), word_start, k == 0);
            tick();
        end
        chk("mrst_a5_idle", out_valid, 1'b0);

        // LSB-first instance, din=1B
        din_l = 8'h1B; din_valid_l = 1'b1;
        tick();
        din_valid_l = 1'b0;
        tick();
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("lsb_bit%0d", k), out_bit_l, lsb_exp[7-k]);
            chk($sformatf("lsb_valid%0d", k), out_valid_l, 1'b1);
            chk($sformatf("lsb_ws%0d", k), word_start_l, k == 0);
            tick();
        end
        chk("lsb_idle_valid", out_valid_l, 1'b0);
        chk("lsb_idle_bit", out_bit_l, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
